// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial sequence detector.
package seq_det_pkg;

  // Word-feeder states: waiting for a word, or shifting one out bit by bit.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Map a requested pattern length onto the usable range 1..max_len.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-level valid/ready bus feeding the serial detector.
interface seq_det_ctrl_if #(
  parameter int unsigned WORD_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  // Producer side drives the word, consumer side answers with ready.
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_matcher.sv
// Bit-history window plus programmable pattern compare. The match output is
// combinational on the incoming bit so the decision is made on the same bit
// that completes the pattern.
module seq_matcher
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = 4,
  parameter int unsigned       LEN_W   = 3,
  parameter logic [PAT_W-1:0]  RST_PAT = PAT_W'(5),
  parameter int unsigned       RST_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             match
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(clamp_len(RST_LEN, PAT_W));

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_plus1;

  // Bit gi of the window takes part in the compare only if it lies inside the pattern length.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (len_q > LEN_W'(gi));
  end

  // Window as it will look once the incoming bit lands in bit 0.
  assign window     = (hist_q << 1) | PAT_W'(bit_in);
  assign fill_plus1 = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign match      = ({1'b0, len_q} <= fill_plus1) &&
                      (((window ^ pattern_q) & len_mask) == '0);

  // Next-state for history, fill level and pattern configuration.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    if (cfg_load) begin
      hist_d    = '0;
      fill_d    = '0;
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
    end else if (shift_en) begin
      hist_d = window;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // Register history and configuration; reset restores the power-on pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PAT;
      len_q     <= LEN_RST;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit feeder for the sequence matcher: accepts words on a valid/ready
// bus, shifts them out MSB-first one bit per clock with no bubble between
// back-to-back words, and counts matches with a sticky threshold interrupt.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned      WORD_W  = 8,
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      LEN_W   = 3,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(5),
  parameter int unsigned      RST_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] thresh,
  seq_det_ctrl_if.slave    in_if,
  output logic             busy,
  output logic             det_pulse,
  output logic [CNT_W-1:0] det_count,
  output logic             irq,
  input  logic             irq_clr
);

  localparam int unsigned      BC_W     = $clog2(WORD_W);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              det_pulse_q, det_pulse_d;
  logic [CNT_W-1:0]  det_count_q, det_count_d;
  logic              irq_q, irq_d;

  logic              last_bit;
  logic              ready;
  logic              accept;
  logic              shift_en;
  logic              cfg_load;
  logic              match;
  logic              hit;
  logic [CNT_W-1:0]  count_inc;

  // Ready in IDLE (unless a config write claims the cycle) and on the last
  // bit of a word, so a following word is picked up without a gap.
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign ready    = rst_n & enable & (((state_q == IDLE) & ~cfg_we) | last_bit);
  assign accept   = in_if.in_valid & ready;
  assign shift_en = (state_q == SHIFT);
  assign cfg_load = cfg_we & (state_q == IDLE);
  assign hit      = shift_en & match;

  assign in_if.in_ready = ready;
  assign busy           = (state_q == SHIFT);
  assign det_pulse      = det_pulse_q;
  assign det_count      = det_count_q;
  assign irq            = irq_q;

  seq_matcher #(
    .PAT_W   (PAT_W),
    .LEN_W   (LEN_W),
    .RST_PAT (RST_PAT),
    .RST_LEN (RST_LEN)
  ) u_matcher (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en    (shift_en),
    .bit_in      (shreg_q[WORD_W-1]),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .match       (match)
  );

  // Feeder FSM next-state: load on accept, shift MSB out, reload or stop on the last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = in_if.in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (last_bit) begin
          bit_cnt_d = '0;
          if (accept) begin
            shreg_d = in_if.in_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating match counter and sticky interrupt; a set beats a same-cycle clear.
  always_comb begin
    count_inc   = (det_count_q == CNT_MAX) ? det_count_q : det_count_q + CNT_W'(1);
    det_pulse_d = hit;
    det_count_d = det_count_q;
    irq_d       = irq_q;
    if (cfg_load) begin
      det_count_d = '0;
      irq_d       = 1'b0;
    end else begin
      if (hit) begin
        det_count_d = count_inc;
      end
      if (hit && (thresh != '0) && (count_inc == thresh)) begin
        irq_d = 1'b1;
      end else if (irq_clr) begin
        irq_d = 1'b0;
      end
    end
  end

  // All control state registered here; reset abandons any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      det_pulse_q <= 1'b0;
      det_count_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      det_pulse_q <= det_pulse_d;
      det_count_q <= det_count_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed word table, multi-cycle corner sequences and
// a randomized run, all checked every cycle against a bit-stream reference model.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int LEN_W  = 3;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             enable;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] thresh;
  logic             irq_clr;
  logic             busy;
  logic             det_pulse;
  logic [CNT_W-1:0] det_count;
  logic             irq;

  seq_det_ctrl_if #(.WORD_W(WORD_W)) bus();

  seq_det_ctrl #(
    .WORD_W  (WORD_W),
    .PAT_W   (PAT_W),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W),
    .RST_PAT (4'b0101),
    .RST_LEN (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .thresh      (thresh),
    .in_if       (bus),
    .busy        (busy),
    .det_pulse   (det_pulse),
    .det_count   (det_count),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit last_accept;

  // Reference model: the stream is a queue of bits, a word is a queue of pending bits.
  bit       m_busy  = 0;
  bit       m_pend[$];
  bit       m_hist[$];
  bit [3:0] m_pat   = 4'b0101;
  int       m_len   = 3;
  int       m_cnt   = 0;
  bit       m_irq   = 0;
  bit       m_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return rst_n && enable && ((!m_busy && !cfg_we) || (m_busy && m_pend.size() == 1));
  endfunction

  task automatic m_tick();
    bit acc;
    bit b;
    bit hit;
    if (!rst_n) begin
      m_busy = 0; m_pend.delete(); m_hist.delete();
      m_pat = 4'b0101; m_len = 3; m_cnt = 0; m_irq = 0; m_pulse = 0;
      return;
    end
    acc = bus.in_valid && m_ready();
    m_pulse = 0;
    if (m_busy) begin
      b = m_pend.pop_front();
      m_hist.push_back(b);
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      hit = (m_hist.size() >= m_len);
      if (hit) begin
        for (int i = 0; i < m_len; i++) begin
          if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hit = 0;
        end
      end
      m_pulse = hit;
      if (hit && m_cnt < 255) m_cnt++;
      if (hit && thresh != 0 && m_cnt == int'(thresh)) m_irq = 1;
      else if (irq_clr) m_irq = 0;
    end else if (cfg_we) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
      m_hist.delete();
      m_cnt = 0;
      m_irq = 0;
    end else if (irq_clr) begin
      m_irq = 0;
    end
    if (acc) begin
      m_pend.delete();
      for (int k = WORD_W - 1; k >= 0; k--) m_pend.push_back(bus.in_data[k]);
      m_busy = 1;
    end else if (m_busy && m_pend.size() == 0) begin
      m_busy = 0;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    last_accept = bus.in_valid && bus.in_ready;
    @(posedge clk);
    cyc++;
    m_tick();
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("det_pulse", 32'(det_pulse), 32'(m_pulse));
    chk("det_count", 32'(det_count), 32'(m_cnt));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic do_reset();
    rst_n = 0; bus.in_valid = 0;
    cycle(); cycle();
    rst_n = 1;
  endtask

  // Send one word from IDLE and record which bit positions produced a pulse.
  task automatic send_word(input logic [7:0] w, output logic [7:0] pmask, output int nbusy);
    bus.in_valid = 1; bus.in_data = w;
    cycle();
    nbusy = int'(busy);
    bus.in_valid = 0;
    for (int k = 0; k < WORD_W; k++) begin
      cycle();
      pmask[k] = det_pulse;
      nbusy += int'(busy);
    end
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] pmask;
    int         cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pm;
    int nb;
    int acc_cyc[3];
    int n_acc;
    int busy_cnt;

    vecs[0] = '{8'b1010_1000, 8'h14, 2};
    vecs[1] = '{8'hAA,        8'h54, 3};
    vecs[2] = '{8'hFF,        8'h00, 0};
    vecs[3] = '{8'h00,        8'h00, 0};
    vecs[4] = '{8'b1011_0101, 8'hA4, 3};
    vecs[5] = '{8'h05,        8'h80, 1};

    rst_n = 0; enable = 1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0;
    thresh = '0; irq_clr = 0; bus.in_valid = 0; bus.in_data = '0;

    do_reset();
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_count", 32'(det_count), 32'(0));

    // Single words from a fresh "101" configuration.
    foreach (vecs[i]) begin
      do_reset();
      send_word(vecs[i].word, pm, nb);
      chk("vec_pulse_mask", 32'(pm), 32'(vecs[i].pmask));
      chk("vec_count", 32'(det_count), 32'(vecs[i].cnt));
      chk("vec_busy_cycles", 32'(nb), 32'(8));
    end

    // Match spanning a word boundary.
    do_reset();
    send_word(8'b0000_0010, pm, nb);
    chk("xword_first_mask", 32'(pm), 32'(0));
    send_word(8'b1000_0000, pm, nb);
    chk("xword_second_mask", 32'(pm), 32'(1));
    chk("xword_count", 32'(det_count), 32'(1));

    // Three back-to-back words with valid held high.
    do_reset();
    n_acc = 0; busy_cnt = 0;
    bus.in_valid = 1; bus.in_data = 8'h3C;
    for (int c = 0; c < 30; c++) begin
      cycle();
      busy_cnt += int'(busy);
      if (last_accept && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        bus.in_data = 8'($urandom);
        if (n_acc == 3) bus.in_valid = 0;
      end
    end
    bus.in_valid = 0;
    chk("b2b_accepts", 32'(n_acc), 32'(3));
    if (n_acc == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(8));
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(8));
    end
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'(24));

    // Threshold interrupt, clear, and set-beats-clear.
    do_reset();
    thresh = 8'd3;
    send_word(8'hAA, pm, nb);
    chk("irq_after_3", 32'(irq), 32'(1));
    irq_clr = 1; cycle(); irq_clr = 0;
    chk("irq_cleared", 32'(irq), 32'(0));
    cfg_we = 1; cfg_pattern = 4'b0101; cfg_len = 3'd3; cycle(); cfg_we = 0;
    bus.in_valid = 1; bus.in_data = 8'hAA; cycle(); bus.in_valid = 0;
    for (int k = 0; k < WORD_W; k++) begin
      if (k == 6) irq_clr = 1;
      cycle();
      irq_clr = 0;
      if (k == 6) chk("irq_set_wins", 32'(irq), 32'(1));
    end

    // Config write mid-word is dropped; in IDLE it reloads and clears.
    do_reset();
    thresh = 8'd2;
    bus.in_valid = 1; bus.in_data = 8'hAA; cycle(); bus.in_valid = 0;
    for (int k = 0; k < WORD_W; k++) begin
      cfg_we = (k == 3); cfg_pattern = 4'b0001; cfg_len = 3'd0;
      cycle();
    end
    cfg_we = 0;
    chk("cfg_mid_ignored_count", 32'(det_count), 32'(3));
    chk("cfg_mid_irq", 32'(irq), 32'(1));
    cfg_we = 1; cycle(); cfg_we = 0;
    chk("cfg_idle_count_clr", 32'(det_count), 32'(0));
    chk("cfg_idle_irq_clr", 32'(irq), 32'(0));
    send_word(8'b1011_0010, pm, nb);
    chk("len1_mask", 32'(pm), 32'(8'h4D));
    chk("len1_count", 32'(det_count), 32'(4));

    // Reset in the middle of a word.
    bus.in_valid = 1; bus.in_data = 8'hAA; cycle(); bus.in_valid = 0;
    for (int k = 0; k < 3; k++) cycle();
    rst_n = 0; cycle(); rst_n = 1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_pulse", 32'(det_pulse), 32'(0));
    chk("midrst_count", 32'(det_count), 32'(0));
    chk("midrst_irq", 32'(irq), 32'(0));
    #1;
    chk("midrst_ready", 32'(bus.in_ready), 32'(1));
    for (int k = 0; k < 8; k++) cycle();
    chk("midrst_idle_busy", 32'(busy), 32'(0));
    send_word(8'b1010_1000, pm, nb);
    chk("midrst_pattern_mask", 32'(pm), 32'(8'h14));
    chk("midrst_pattern_count", 32'(det_count), 32'(2));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      enable       = ($urandom_range(0, 9) != 0);
      bus.in_valid = ($urandom_range(0, 1) != 0);
      bus.in_data  = 8'($urandom);
      cfg_we       = ($urandom_range(0, 19) == 0);
      cfg_pattern  = 4'($urandom);
      cfg_len      = 3'($urandom);
      thresh       = 8'($urandom_range(0, 6));
      irq_clr      = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
